// File: rtl/hip_rst_seq_if.sv
// Board-level reset bundle between the HIP reset sequencer and the rest of the CPLD.
// Request/clock-status inputs come from the board; staged reset outputs go back out.
interface hip_rst_seq_if #(
  parameter int unsigned NREQ = 3
);

  logic [NREQ-1:0] REQ_RST_;
  logic            CLK_OK;
  logic            PCI_RST_;
  logic            PCI_SLOT_RST_;
  logic            PMC_RST_;
  logic            RST_BUSY;
  logic [NREQ:0]   RST_CAUSE;

  // Sequencer side: samples requests and clock status, drives the resets.
  modport master (
    input  REQ_RST_,
    input  CLK_OK,
    output PCI_RST_,
    output PCI_SLOT_RST_,
    output PMC_RST_,
    output RST_BUSY,
    output RST_CAUSE
  );

  // Board side: raises requests and clock status, observes the resets.
  modport slave (
    output REQ_RST_,
    output CLK_OK,
    input  PCI_RST_,
    input  PCI_SLOT_RST_,
    input  PMC_RST_,
    input  RST_BUSY,
    input  RST_CAUSE
  );

endinterface

// File: rtl/hip_rst_seq.sv
// HIP CPLD board reset sequencer: debounces warm-reset requests, releases PCI, slot
// and PMC resets in staged order with programmable gaps, and latches the last reset cause.
module hip_rst_seq #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned T_HOLD     = 'h0AA,
  parameter int unsigned T_SLOT     = 'h100,
  parameter int unsigned T_PMC      = 'hF00
) (
  input  logic          RST_CPLD_CLK,
  input  logic          PUSH_RST_,
  hip_rst_seq_if.master bus
);

  localparam int unsigned DEB_W   = 8;
  localparam int unsigned CAUSE_W = NREQ + 1;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_REL_PCI  = 2'd1,
    S_REL_SLOT = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  logic [NREQ-1:0]    r_req_m;
  logic [NREQ-1:0]    r_req_s;
  logic               r_ok_m;
  logic               r_ok_s;
  logic [DEB_W-1:0]   r_dcnt [NREQ];
  logic [NREQ-1:0]    w_qual;
  logic               w_any_qual;

  state_t             r_state;
  state_t             w_nstate;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_ncnt;

  logic               r_pci_rst_n;
  logic               r_slot_rst_n;
  logic               r_pmc_rst_n;
  logic               r_busy;
  logic [CAUSE_W-1:0] r_cause;

  // Two-flop synchronisers; requests idle high, clock status idles "not ok".
  always_ff @(posedge RST_CPLD_CLK or negedge PUSH_RST_) begin
    if (!PUSH_RST_) begin
      r_req_m <= '1;
      r_req_s <= '1;
      r_ok_m  <= 1'b0;
      r_ok_s  <= 1'b0;
    end else begin
      r_req_m <= bus.REQ_RST_;
      r_req_s <= r_req_m;
      r_ok_m  <= bus.CLK_OK;
      r_ok_s  <= r_ok_m;
    end
  end

  // Per-request low-time counters, saturating so a held request stays qualified.
  always_ff @(posedge RST_CPLD_CLK or negedge PUSH_RST_) begin
    if (!PUSH_RST_) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (r_req_s[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] != DEB_W'(DEB_CYCLES)) begin
          r_dcnt[i] <= r_dcnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_qual = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_qual[i] = (r_dcnt[i] == DEB_W'(DEB_CYCLES));
    end
  end

  assign w_any_qual = |w_qual;

  // Stage sequencing; a qualified request aborts from any state, clock loss only mid-release.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      S_HOLD: begin
        if (r_ok_s && !w_any_qual) begin
          if (r_cnt == CNT_W'(T_HOLD - 1)) begin
            w_nstate = S_REL_PCI;
            w_ncnt   = '0;
          end else begin
            w_ncnt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_ncnt = '0;
        end
      end
      S_REL_PCI: begin
        if (w_any_qual || !r_ok_s) begin
          w_nstate = S_HOLD;
          w_ncnt   = '0;
        end else if (r_cnt == CNT_W'(T_SLOT - 1)) begin
          w_nstate = S_REL_SLOT;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + CNT_W'(1);
        end
      end
      S_REL_SLOT: begin
        if (w_any_qual || !r_ok_s) begin
          w_nstate = S_HOLD;
          w_ncnt   = '0;
        end else if (r_cnt == CNT_W'(T_PMC - 1)) begin
          w_nstate = S_RUN;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_ncnt = '0;
        if (w_any_qual) begin
          w_nstate = S_HOLD;
        end
      end
      default: begin
        w_nstate = S_HOLD;
        w_ncnt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge RST_CPLD_CLK or negedge PUSH_RST_) begin
    if (!PUSH_RST_) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_pci_rst_n  <= 1'b0;
      r_slot_rst_n <= 1'b0;
      r_pmc_rst_n  <= 1'b0;
      r_busy       <= 1'b1;
      r_cause      <= CAUSE_W'(1);
    end else begin
      r_state      <= w_nstate;
      r_cnt        <= w_ncnt;
      r_pci_rst_n  <= (w_nstate != S_HOLD);
      r_slot_rst_n <= (w_nstate == S_REL_SLOT) || (w_nstate == S_RUN);
      r_pmc_rst_n  <= (w_nstate == S_RUN);
      r_busy       <= (w_nstate != S_RUN);
      // A fresh abort replaces the cause; requests arriving while held accumulate.
      if (w_any_qual) begin
        if (r_state == S_HOLD) begin
          r_cause <= r_cause | {w_qual, 1'b0};
        end else begin
          r_cause <= {w_qual, 1'b0};
        end
      end
    end
  end

  assign bus.PCI_RST_      = r_pci_rst_n;
  assign bus.PCI_SLOT_RST_ = r_slot_rst_n;
  assign bus.PMC_RST_      = r_pmc_rst_n;
  assign bus.RST_BUSY      = r_busy;
  assign bus.RST_CAUSE     = r_cause;

endmodule

// File: tb/tb_hip_rst_seq.sv
// Directed bench for hip_rst_seq: cold boot, glitch reject, warm resets, clock-loss abort
// and asynchronous push reset, with hand-computed edge timing.
module tb_hip_rst_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hip_rst_seq_if #(.NREQ(3)) bus ();

  hip_rst_seq #(
    .NREQ       (3),
    .DEB_CYCLES (4),
    .CNT_W      (12),
    .T_HOLD     (8),
    .T_SLOT     (5),
    .T_PMC      (6)
  ) dut (
    .RST_CPLD_CLK (clk),
    .PUSH_RST_    (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pci, input logic slot,
                         input logic pmc, input logic busy);
    chk({tag, "_pci"},  8'(bus.PCI_RST_),      8'(pci));
    chk({tag, "_slot"}, 8'(bus.PCI_SLOT_RST_), 8'(slot));
    chk({tag, "_pmc"},  8'(bus.PMC_RST_),      8'(pmc));
    chk({tag, "_busy"}, 8'(bus.RST_BUSY),      8'(busy));
  endtask

  task automatic chk_cause(input string tag, input logic [3:0] exp);
    chk({tag, "_cause"}, 8'(bus.RST_CAUSE), 8'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.REQ_RST_ = 3'b111;
    bus.CLK_OK   = 1'b1;

    // Cold boot
    tick(3);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("rst", 4'b0001);
    @(negedge clk) rst_n = 1'b1;
    tick(9);  chk_out("boot_e9",  1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("boot_e10", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(4);  chk_out("boot_e14", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("boot_e15", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(5);  chk_out("boot_e20", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);  chk_out("boot_e21", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cause("boot", 4'b0001);

    // Glitch shorter than the debounce window
    @(negedge clk) bus.REQ_RST_[1] = 1'b0;
    tick(3);
    @(negedge clk) bus.REQ_RST_[1] = 1'b1;
    tick(3);  chk_out("glitch_a", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(5);  chk_out("glitch_b", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cause("glitch", 4'b0001);

    // Warm reset from request 0
    @(negedge clk) bus.REQ_RST_[0] = 1'b0;
    tick(6);  chk_out("warm_e6", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);  chk_out("warm_e7", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("warm_e7", 4'b0010);
    tick(3);  chk_cause("warm_e10", 4'b0010);
    @(negedge clk) bus.REQ_RST_[0] = 1'b1;
    tick(10); chk_out("warm_r10", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("warm_r11", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(4);  chk_out("warm_r15", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("warm_r16", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(5);  chk_out("warm_r21", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);  chk_out("warm_r22", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cause("warm_run", 4'b0010);

    // Simultaneous requests 0 and 2
    @(negedge clk) begin
      bus.REQ_RST_[0] = 1'b0;
      bus.REQ_RST_[2] = 1'b0;
    end
    tick(6);  chk_out("simul_e6", 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk) begin
      bus.REQ_RST_[0] = 1'b1;
      bus.REQ_RST_[2] = 1'b1;
    end
    tick(1);  chk_out("simul_e7", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("simul_e7", 4'b1010);
    tick(9);  chk_out("simul_r10", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("simul_r11", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(5);  chk_out("simul_r16", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(6);  chk_out("simul_r22", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cause("simul_run", 4'b1010);

    // Clock loss while running has no effect
    @(negedge clk) bus.CLK_OK = 1'b0;
    tick(4);  chk_out("okrun", 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk) bus.CLK_OK = 1'b1;
    tick(3);

    // Warm reset from request 1, then clock loss in REL_SLOT
    @(negedge clk) bus.REQ_RST_[1] = 1'b0;
    tick(5);
    @(negedge clk) bus.REQ_RST_[1] = 1'b1;
    tick(1);  chk_out("abort_e6", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);  chk_out("abort_e7", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("abort_e7", 4'b0100);
    tick(8);  chk_out("abort_e15", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("abort_e16", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(5);  chk_out("abort_e21", 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk) bus.CLK_OK = 1'b0;
    tick(2);  chk_out("abort_e23", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);  chk_out("abort_e24", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("abort_e24", 4'b0100);
    tick(3);  chk_out("abort_wait", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk) bus.CLK_OK = 1'b1;
    tick(9);  chk_out("okret_e9",  1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);  chk_out("okret_e10", 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous push reset between edges while in REL_PCI
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_cause("async", 4'b0001);
    @(negedge clk) rst_n = 1'b1;
    tick(20); chk_out("reboot_e20", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);  chk_out("reboot_e21", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cause("reboot", 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
